// File: rtl/bw_seq_mult_ctrl.sv
// Sequential Baugh-Wooley multiplier: one partial-product row per cycle through a shared fa chain.
// Optional macro BW_SEQ_MULT_UNSIGNED_SEL_EN adds tc_i to select signed (1) or unsigned (0) operation.

module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// state | meaning
// IDLE  | waiting for start_i; operands and accumulator hold
// RUN   | adding partial-product row j_q into acc_q, one row per cycle
// DONE  | done_o high for one cycle, p_o holds the final product
module bw_seq_mult_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
`ifdef BW_SEQ_MULT_UNSIGNED_SEL_EN
    input  logic           tc_i,
`endif
    output logic           busy_o,
    output logic           done_o,
    output logic [2*N-1:0] p_o
);
    localparam int JW = $clog2(N);
    localparam logic [JW-1:0]  J_LAST  = JW'(N - 1);
    localparam logic [2*N-1:0] BW_CORR = {1'b1, {(N-2){1'b0}}, 1'b1, {N{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [N-1:0]    ra_q, rb_q;
    logic [JW-1:0]   j_q;
    logic [2*N-1:0]  acc_q, p_q;
    logic            busy_q, done_q;
    logic            signed_mode, start_signed;
    logic            accept;

    logic [N-1:0]    row_d;
    logic [2*N-1:0]  addend_d, sum_d;
    logic [2*N-1:0]  carry;

    // A start seen while leaving DONE counts as the IDLE acceptance, giving N+1 cycle throughput.
    assign accept = start_i && (state_q != RUN);

`ifdef BW_SEQ_MULT_UNSIGNED_SEL_EN
    logic tc_q;
    always_ff @(posedge clk) begin
        if (rst)         tc_q <= 1'b1;
        else if (accept) tc_q <= tc_i;
    end
    assign signed_mode  = tc_q;
    assign start_signed = tc_i;
`else
    assign signed_mode  = 1'b1;
    assign start_signed = 1'b1;
`endif

    always_comb begin
        row_d = '0;
        for (int i = 0; i < N; i++) begin
            row_d[i] = (ra_q[i] & rb_q[j_q])
                     ^ (signed_mode && ((i == N - 1) != (j_q == J_LAST)));
        end
    end

    assign addend_d = {{N{1'b0}}, row_d} << j_q;
    assign carry[0] = 1'b0;

    genvar g;
    generate
        for (g = 0; g < 2*N; g++) begin : g_chain
            if (g < 2*N - 1) begin : g_fa
                fa u_fa (
                    .a_i  (acc_q[g]),
                    .b_i  (addend_d[g]),
                    .ci_i (carry[g]),
                    .s_o  (sum_d[g]),
                    .co_o (carry[g+1])
                );
            end else begin : g_top
                assign sum_d[g] = acc_q[g] ^ addend_d[g] ^ carry[g];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        ra_q    <= a_i;
                        rb_q    <= b_i;
                        j_q     <= '0;
                        acc_q   <= start_signed ? BW_CORR : '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else if (state_q == DONE) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= sum_d;
                    if (j_q == J_LAST) begin
                        p_q     <= sum_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign p_o    = p_q;

endmodule

// File: tb/tb_bw_seq_mult_ctrl.sv
// Directed bench for bw_seq_mult_ctrl: vector table plus corner sequences (abort, ignored starts, back-to-back).
`timescale 1ns/1ps

module tb_bw_seq_mult_ctrl;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a, b;
`ifdef BW_SEQ_MULT_UNSIGNED_SEL_EN
    logic           tc;
`endif
    logic           busy_o, done_o;
    logic [2*N-1:0] p_o;

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] prev_exp;

    typedef struct {
        string          name;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic           tc;
        logic [2*N-1:0] p;
    } vec_t;

    vec_t vecs[$];

    bw_seq_mult_ctrl #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
`ifdef BW_SEQ_MULT_UNSIGNED_SEL_EN
        .tc_i    (tc),
`endif
        .busy_o  (busy_o),
        .done_o  (done_o),
        .p_o     (p_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        a = v.a;
        b = v.b;
`ifdef BW_SEQ_MULT_UNSIGNED_SEL_EN
        tc = v.tc;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~v.a;
        b = ~v.b;
        chk({v.name, " busy_rise"}, 32'(busy_o), 32'd1);
        chk({v.name, " p_hold"}, 32'(p_o), 32'(prev_exp));
        n = 0;
        do begin
            tick();
            n++;
        end while (!done_o && n < 20);
        chk({v.name, " latency"}, 32'(n), 32'(N));
        chk({v.name, " p"}, 32'(p_o), 32'(v.p));
        tick();
        chk({v.name, " busy_fall"}, 32'(busy_o), 32'd0);
        chk({v.name, " done_fall"}, 32'(done_o), 32'd0);
        chk({v.name, " p_stable"}, 32'(p_o), 32'(v.p));
        prev_exp = v.p;
    endtask

    initial begin
        int dones;
        int done_t[$];
        vec_t v;

        vecs.push_back('{"3x5",        8'd3,    8'd5,    1'b1, 16'h000F});
        vecs.push_back('{"m1xm1",      8'hFF,   8'hFF,   1'b1, 16'h0001});
        vecs.push_back('{"m128xm128",  8'h80,   8'h80,   1'b1, 16'h4000});
        vecs.push_back('{"m128x127",   8'h80,   8'h7F,   1'b1, 16'hC080});
        vecs.push_back('{"0xm77",      8'd0,    8'hB3,   1'b1, 16'h0000});
        vecs.push_back('{"127x127",    8'h7F,   8'h7F,   1'b1, 16'h3F01});
        vecs.push_back('{"1xm128",     8'h01,   8'h80,   1'b1, 16'hFF80});
        vecs.push_back('{"5xm7",       8'd5,    8'hF9,   1'b1, 16'hFFDD});
`ifdef BW_SEQ_MULT_UNSIGNED_SEL_EN
        vecs.push_back('{"u_FFxFF",    8'hFF,   8'hFF,   1'b0, 16'hFE01});
        vecs.push_back('{"s_FFxFF",    8'hFF,   8'hFF,   1'b1, 16'h0001});
        vecs.push_back('{"u_80x7F",    8'h80,   8'h7F,   1'b0, 16'h3F80});
        tc = 1'b1;
`endif

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        prev_exp = '0;
        tick();
        tick();
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        chk("reset p", 32'(p_o), 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // start pulses at edges 3 and 8 of a running multiply are dropped
        a = 8'd7; b = 8'd9; start = 1'b1;
        tick();
        dones = 0;
        for (int c = 1; c <= 12; c++) begin
            start = (c == 3 || c == 8);
            a = 8'd2; b = 8'd2;
            tick();
            if (done_o) begin
                dones++;
                chk("ignore done_edge", 32'(c), 32'd8);
                chk("ignore p", 32'(p_o), 32'h3F);
            end
        end
        start = 1'b0;
        chk("ignore done_count", 32'(dones), 32'd1);
        chk("ignore idle", 32'(busy_o), 32'd0);
        chk("ignore p_final", 32'(p_o), 32'h3F);
        prev_exp = 16'h003F;

        // reset mid-operation aborts
        a = 8'd100; b = 8'hFD; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 32'(busy_o), 32'd0);
        chk("abort done", 32'(done_o), 32'd0);
        chk("abort p", 32'(p_o), 32'd0);
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done_o) dones++;
        end
        chk("abort no_done", 32'(dones), 32'd0);
        prev_exp = '0;
        v = '{"after_abort", 8'hFE, 8'd6, 1'b1, 16'hFFF4};
        run_vec(v);

        // start held high: back-to-back multiplies every N+1 cycles
        a = 8'd10; b = 8'hF6; start = 1'b1;
        tick();
        for (int c = 1; c < 30; c++) begin
            tick();
            if (done_o) begin
                done_t.push_back(c);
                chk("b2b p", 32'(p_o), 32'hFF9C);
            end
        end
        start = 1'b0;
        chk("b2b count", 32'(done_t.size()), 32'd3);
        if (done_t.size() == 3) begin
            chk("b2b t0", 32'(done_t[0]), 32'd8);
            chk("b2b t1", 32'(done_t[1]), 32'd17);
            chk("b2b t2", 32'(done_t[2]), 32'd26);
        end
        for (int c = 0; c < 12; c++) tick();
        chk("b2b idle", 32'(busy_o), 32'd0);
        chk("b2b p_final", 32'(p_o), 32'hFF9C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule
